// File: rtl/rv_core_pkg.sv
// Shared core-wide widths, register-address types and the write-port grant encoding.
package rv_core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  // x0 is never tracked, so a lookup of x0 can never report a hazard.
  function automatic logic pendHit(input logic [NUM_REGS-1:0] pend, input reg_addr_t idx);
    return (idx != '0) && pend[idx];
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination bitmask for long-latency ops plus the issue-stage hazard lookup.
module reg_scoreboard
  import rv_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_set_valid,
  input  logic [REG_ADDR_W-1:0] i_set_rd,
  input  logic                  i_clr_valid,
  input  logic [REG_ADDR_W-1:0] i_clr_rd,
  input  logic                  i_chk_valid,
  input  logic [REG_ADDR_W-1:0] i_chk_rs1,
  input  logic [REG_ADDR_W-1:0] i_chk_rs2,
  input  logic [REG_ADDR_W-1:0] i_chk_rd,
  output logic [NUM_REGS-1:0]   o_pending,
  output logic                  o_stall
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pendingNext;
  logic                w_hitRs1;
  logic                w_hitRs2;
  logic                w_hitRd;

  // Clear is applied before set so a new issue to the completing register keeps it pending.
  always_comb begin
    w_pendingNext = r_pending;
    if (i_clr_valid) begin
      w_pendingNext[i_clr_rd] = 1'b0;
    end
    if (i_set_valid && (i_set_rd != '0)) begin
      w_pendingNext[i_set_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pendingNext;
    end
  end

  // Lookups see only the registered mask, so a completing register still stalls this cycle.
  assign w_hitRs1  = pendHit(r_pending, i_chk_rs1);
  assign w_hitRs2  = pendHit(r_pending, i_chk_rs2);
  assign w_hitRd   = pendHit(r_pending, i_chk_rd);
  assign o_stall   = i_chk_valid && (w_hitRs1 || w_hitRs2 || w_hitRd);
  assign o_pending = r_pending;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file's single write port between pipeline writeback (A) and the
// long-latency completion path (B), with starvation protection for B and a RAW/WAW scoreboard.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_hold,
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic            chk_valid,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            stall,
  output logic [31:0]     pending,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  import rv_core_pkg::*;

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [3:0] CNT_MAX = 4'hF;

  logic [3:0]            r_starveCnt;
  logic                  w_hold;
  grant_e                w_grant;
  logic                  w_bFire;
  logic                  w_sbStall;
  logic [NUM_REGS-1:0]   w_pending;
  logic                  w_we;
  logic [REG_ADDR_W-1:0] w_waddr;
  logic [XLEN-1:0]       w_wdata;

  assign w_hold = !rst && b_valid && (r_starveCnt >= LIMIT);

  // A has priority unless B has been refused long enough to force A to hold.
  always_comb begin
    w_grant = GNT_NONE;
    if (!rst) begin
      if (a_valid && !w_hold) begin
        w_grant = GNT_A;
      end else if (b_valid) begin
        w_grant = GNT_B;
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    case (w_grant)
      GNT_A: begin
        w_we    = (a_rd != '0);
        w_waddr = a_rd;
        w_wdata = a_data;
      end
      GNT_B: begin
        w_we    = (b_rd != '0);
        w_waddr = b_rd;
        w_wdata = b_data;
      end
      default: begin
        w_we    = 1'b0;
      end
    endcase
  end

  assign w_bFire = b_valid && (w_grant == GNT_B);

  // Counts consecutive refused B cycles; any B transfer or idle B restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starveCnt <= '0;
    end else if (!b_valid || w_bFire) begin
      r_starveCnt <= '0;
    end else if (r_starveCnt != CNT_MAX) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_set_valid (iss_valid),
    .i_set_rd    (iss_rd),
    .i_clr_valid (w_bFire),
    .i_clr_rd    (b_rd),
    .i_chk_valid (chk_valid),
    .i_chk_rs1   (chk_rs1),
    .i_chk_rs2   (chk_rs2),
    .i_chk_rd    (chk_rd),
    .o_pending   (w_pending),
    .o_stall     (w_sbStall)
  );

  assign a_hold   = w_hold;
  assign b_ready  = (w_grant == GNT_B);
  assign stall    = !rst && w_sbStall;
  assign pending  = w_pending;
  assign rf_we    = w_we;
  assign rf_waddr = w_waddr;
  assign rf_wdata = w_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a cycle model predicts every output, directed
// phases walk the key scenarios, then a random phase stresses arbitration and the scoreboard.
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_hold;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        chk_valid;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        stall;
  logic [31:0] pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_hold    (a_hold),
    .b_valid   (b_valid),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_valid (chk_valid),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .stall     (stall),
    .pending   (pending),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  // Register file stand-in with no x0 guard, so a stray x0 write would be visible.
  logic [31:0] rfModel [32] = '{default: 32'h0};
  always @(negedge clk) begin
    if (rf_we) rfModel[rf_waddr] <= rf_wdata;
  end

  always @(negedge clk) begin
    if (!rst && a_valid && !a_hold && (a_rd != 5'd0)) begin
      assert (pending[a_rd] !== 1'b1)
        else $error("[TB] protocol violation: A wrote pending x%0d", a_rd);
    end
  end

  typedef struct packed {
    logic        pendKnown;
    logic        grant;
    logic        hold;
    logic        bReady;
    logic        we;
    logic        stall;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pend;
  } exp_t;

  exp_t        expQ [$];
  logic [31:0] mPend  = 32'h0;
  logic [3:0]  mCnt   = 4'h0;
  logic        mKnown = 1'b0;
  logic        mGrantB;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    rst = 1'b0; a_valid = 1'b0; a_rd = 5'd0; a_data = 32'h0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'h0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    chk_valid = 1'b0; chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
  endtask

  function automatic logic hit(input logic [4:0] r);
    return (r != 5'd0) && mPend[r];
  endfunction

  // Called at posedge+1 with inputs already driven; returns at posedge+4, before the negedge.
  task automatic applyStimulus();
    exp_t e;
    logic h, ga, gb;
    h  = !rst && b_valid && (mCnt >= 4'(LIMIT));
    ga = !rst && a_valid && !h;
    gb = !rst && !ga && b_valid;
    e.pendKnown = mKnown;
    e.grant     = ga || gb;
    e.hold      = h;
    e.bReady    = gb;
    e.we        = (ga && a_rd != 5'd0) || (gb && b_rd != 5'd0);
    e.stall     = !rst && chk_valid && (hit(chk_rs1) || hit(chk_rs2) || hit(chk_rd));
    e.waddr     = ga ? a_rd : b_rd;
    e.wdata     = ga ? a_data : b_data;
    e.pend      = mPend;
    mGrantB     = gb;
    expQ.push_back(e);
    #3;
    e = expQ.pop_front();
    checkOutput("a_hold", a_hold, e.hold);
    checkOutput("b_ready", b_ready, e.bReady);
    checkOutput("rf_we", rf_we, e.we);
    checkOutput("stall", stall, e.stall);
    if (e.pendKnown) checkOutput("pending", pending, e.pend);
    if (e.grant) begin
      checkOutput("rf_waddr", rf_waddr, e.waddr);
      checkOutput("rf_wdata", rf_wdata, e.wdata);
    end
  endtask

  // Advances the model across the posedge using the inputs that were held through it.
  task automatic finishCycle();
    @(posedge clk);
    if (rst) begin
      mPend = 32'h0; mCnt = 4'h0; mKnown = 1'b1;
    end else begin
      if (mGrantB) mPend[b_rd] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) mPend[iss_rd] = 1'b1;
      if (!b_valid || mGrantB) mCnt = 4'h0;
      else if (mCnt != 4'hF) mCnt = mCnt + 4'd1;
    end
    #1;
  endtask

  task automatic cycle();
    applyStimulus();
    finishCycle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset with every request active
    for (int i = 0; i < 2; i++) begin
      idle(); rst = 1'b1;
      a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
      b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h22;
      iss_valid = 1'b1; iss_rd = 5'd6;
      chk_valid = 1'b1; chk_rs1 = 5'd6;
      applyStimulus();
      checkOutput("rst_we", rf_we, 1'b0);
      checkOutput("rst_bready", b_ready, 1'b0);
      checkOutput("rst_hold", a_hold, 1'b0);
      finishCycle();
    end
    checkOutput("rst_pending", pending, 32'h0);

    idle(); iss_valid = 1'b1; iss_rd = 5'd9;
    cycle();
    checkOutput("iss_first_edge", pending, 32'h0000_0200);

    // A alone
    idle(); a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("a_we", rf_we, 1'b1);
    checkOutput("a_waddr", rf_waddr, 5'd5);
    checkOutput("a_wdata", rf_wdata, 32'hDEADBEEF);
    finishCycle();
    checkOutput("x5", rfModel[5], 32'hDEADBEEF);

    // Contention: A first, B next cycle
    idle(); a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA5A5_0003;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h1234;
    applyStimulus();
    checkOutput("cont_bready0", b_ready, 1'b0);
    checkOutput("cont_waddr", rf_waddr, 5'd3);
    finishCycle();
    checkOutput("x3", rfModel[3], 32'hA5A5_0003);
    a_valid = 1'b0;
    applyStimulus();
    checkOutput("cont_bready1", b_ready, 1'b1);
    finishCycle();
    checkOutput("x7", rfModel[7], 32'h1234);

    // Starvation: forced B grant at cycle 4 and again at cycle 9
    idle(); b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9999;
    for (int c = 0; c < 10; c++) begin
      a_valid = 1'b1; a_rd = 5'd4; a_data = 32'(c);
      if (c >= 5) begin b_rd = 5'd12; b_data = 32'hC; end
      applyStimulus();
      checkOutput("starve_hold", a_hold, (c == 4 || c == 9));
      checkOutput("starve_bready", b_ready, (c == 4 || c == 9));
      finishCycle();
    end
    checkOutput("x9", rfModel[9], 32'h9999);
    checkOutput("starve_pending", pending, 32'h0);

    // Scoreboard: RAW stall, completion, set-wins
    idle(); iss_valid = 1'b1; iss_rd = 5'd10;
    cycle();
    idle(); chk_valid = 1'b1; chk_rs1 = 5'd10;
    applyStimulus();
    checkOutput("sb_stall_issued", stall, 1'b1);
    finishCycle();
    b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hAA;
    applyStimulus();
    checkOutput("sb_stall_completing", stall, 1'b1);
    finishCycle();
    idle(); chk_valid = 1'b1; chk_rs1 = 5'd10;
    applyStimulus();
    checkOutput("sb_stall_after", stall, 1'b0);
    finishCycle();
    idle(); iss_valid = 1'b1; iss_rd = 5'd10;
    cycle();
    b_valid = 1'b1; b_rd = 5'd10;
    cycle();
    checkOutput("sb_set_wins", pending, 32'h0000_0400);
    iss_rd = 5'd13;
    cycle();
    checkOutput("sb_set_and_clr", pending, 32'h0000_2000);
    idle(); chk_valid = 1'b1; chk_rd = 5'd13;
    applyStimulus();
    checkOutput("sb_waw_stall", stall, 1'b1);
    finishCycle();
    idle(); b_valid = 1'b1; b_rd = 5'd13;
    cycle();

    // x0 handling
    idle(); b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF_FFFF;
    applyStimulus();
    checkOutput("x0_bready", b_ready, 1'b1);
    checkOutput("x0_we", rf_we, 1'b0);
    finishCycle();
    checkOutput("x0_value", rfModel[0], 32'h0);
    idle(); iss_valid = 1'b1; iss_rd = 5'd14;
    cycle();
    iss_rd = 5'd0;
    cycle();
    checkOutput("x0_iss", pending, 32'h0000_4000);
    idle(); chk_valid = 1'b1; chk_rs1 = 5'd1; chk_rs2 = 5'd0;
    applyStimulus();
    checkOutput("x0_chk", stall, 1'b0);
    finishCycle();
    idle(); b_valid = 1'b1; b_rd = 5'd14;
    cycle();

    // Reset during a B request drops the transfer and clears pending
    idle(); iss_valid = 1'b1; iss_rd = 5'd15;
    cycle();
    idle(); rst = 1'b1; b_valid = 1'b1; b_rd = 5'd15; b_data = 32'h5555;
    applyStimulus();
    checkOutput("rst_mid_bready", b_ready, 1'b0);
    finishCycle();
    checkOutput("rst_mid_pending", pending, 32'h0);
    checkOutput("rst_mid_x15", rfModel[15], 32'h0);

    // Random traffic; A never targets a register the model believes pending
    for (int n = 0; n < 300; n++) begin
      idle();
      a_valid   = ($urandom_range(0, 3) != 0);
      a_rd      = 5'($urandom);
      a_data    = $urandom;
      if (mPend[a_rd]) a_rd = 5'd0;
      b_valid   = ($urandom_range(0, 1) != 0);
      b_rd      = 5'($urandom);
      b_data    = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom);
      chk_valid = ($urandom_range(0, 1) != 0);
      chk_rs1   = 5'($urandom);
      chk_rs2   = 5'($urandom);
      chk_rd    = 5'($urandom);
      cycle();
    end

    idle();
    cycle();
    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
